// File: rtl/acc_seq_if.sv
// Bundles the sequencer's ROM, ALU-flag and datapath-strobe signals.
// master = acc_sequencer, slave = program ROM / datapath side.
interface acc_seq_if #(
  parameter int PC_W = 5
) ();
  logic            start;
  logic [8:0]      instr;
  logic            alu_c;
  logic            alu_ze;
  logic [PC_W-1:0] rom_addr;
  logic [2:0]      f;
  logic [4:0]      operand;
  logic            en_db;
  logic            en_ff;
  logic            en_r;
  logic            busy;
  logic            halted;

  modport master (
    input  start, instr, alu_c, alu_ze,
    output rom_addr, f, operand, en_db, en_ff, en_r, busy, halted
  );

  modport slave (
    output start, instr, alu_c, alu_ze,
    input  rom_addr, f, operand, en_db, en_ff, en_r, busy, halted
  );
endinterface

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the 5-bit accumulator datapath.
// Optional macro ACC_SEQ_COND_JUMP_EN adds zero/carry flags and JZ/JC.
module acc_sequencer #(
  parameter int PC_W = 5
) (
  input  logic      clk,
  input  logic      reset,
  acc_seq_if.master bus
);
  localparam logic [3:0] OP_LDI   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_NANDI = 4'b0100;
  localparam logic [3:0] OP_OUT   = 4'b0101;
  localparam logic [3:0] OP_JMP   = 4'b0110;
  localparam logic [3:0] OP_JZ    = 4'b0111;
  localparam logic [3:0] OP_JC    = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [8:0]      r_ir;
  logic [3:0]      w_op;
  logic [4:0]      w_imm;
  logic            w_take_jump;
  logic            w_alu_op;
  logic            w_restart;
  logic [2:0]      w_f;
  logic [4:0]      w_operand;
  logic            w_en_db, w_en_ff, w_en_r;

  assign w_op      = r_ir[8:5];
  assign w_imm     = r_ir[4:0];
  assign w_restart = ((r_state == S_IDLE) || (r_state == S_HALT)) && bus.start;

`ifdef ACC_SEQ_COND_JUMP_EN
  logic r_zflag, r_cflag;
`else
  logic w_unused;
  assign w_unused = bus.alu_c ^ bus.alu_ze;
`endif

  always_comb begin
    w_next      = r_state;
    w_take_jump = 1'b0;
    w_alu_op    = 1'b0;
    w_f         = 3'b000;
    w_operand   = 5'd0;
    w_en_db     = 1'b0;
    w_en_ff     = 1'b0;
    w_en_r      = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: if (bus.start) w_next = S_FETCH;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          OP_LDI, OP_ADDI, OP_SUBI, OP_NANDI: begin
            w_alu_op  = 1'b1;
            w_operand = w_imm;
            w_en_db   = 1'b1;
            w_en_ff   = 1'b1;
            case (w_op)
              OP_LDI:  w_f = 3'b010;
              OP_ADDI: w_f = 3'b011;
              OP_SUBI: w_f = 3'b001;
              default: w_f = 3'b100;
            endcase
          end
          OP_OUT:  w_en_r = 1'b1;
          OP_JMP:  w_take_jump = 1'b1;
`ifdef ACC_SEQ_COND_JUMP_EN
          OP_JZ:   w_take_jump = r_zflag;
          OP_JC:   w_take_jump = r_cflag;
`endif
          OP_HALT: w_next = S_HALT;
          default: ;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Jump targets are zero-extended; sequential pc wraps modulo 2^PC_W.
  assign w_pc_next = w_take_jump ? PC_W'(w_imm) : r_pc + PC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart)
        r_pc <= '0;
      if (r_state == S_DECODE)
        r_ir <= bus.instr;
      if ((r_state == S_EXEC) && (w_op != OP_HALT))
        r_pc <= w_pc_next;
    end
  end

`ifdef ACC_SEQ_COND_JUMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zflag <= 1'b0;
      r_cflag <= 1'b0;
    end else if (w_restart) begin
      r_zflag <= 1'b0;
      r_cflag <= 1'b0;
    end else if ((r_state == S_EXEC) && w_alu_op) begin
      r_zflag <= bus.alu_ze;
      r_cflag <= bus.alu_c;
    end
  end
`endif

  assign bus.rom_addr = r_pc;
  assign bus.f        = w_f;
  assign bus.operand  = w_operand;
  assign bus.en_db    = w_en_db;
  assign bus.en_ff    = w_en_ff;
  assign bus.en_r     = w_en_r;
  assign bus.busy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign bus.halted   = (r_state == S_HALT);
endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a synchronous ROM and a small ALU/accumulator model.
module tb_acc_sequencer;
  localparam logic [3:0] LDI = 4'b0001, ADDI = 4'b0010, SUBI = 4'b0011, OUT = 4'b0101;
  localparam logic [3:0] JZ = 4'b0111, JC = 4'b1000, HLT = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0, n_total = 0, cyc = 0;

  acc_seq_if #(.PC_W(5)) bus ();
  acc_sequencer #(.PC_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [8:0] rom [0:31];
  always @(posedge clk) bus.instr <= rom[bus.rom_addr];

  logic [4:0] acc;
  logic [5:0] alu_full;
  always_comb begin
    case (bus.f)
      3'b010:  alu_full = {1'b0, bus.operand};
      3'b011:  alu_full = {1'b0, acc} + {1'b0, bus.operand};
      3'b001:  alu_full = {1'b0, acc} - {1'b0, bus.operand};
      3'b100:  alu_full = {1'b0, ~(acc & bus.operand)};
      default: alu_full = {1'b0, acc};
    endcase
  end
  assign bus.alu_c  = alu_full[5];
  assign bus.alu_ze = (alu_full[4:0] == 5'd0);
  always @(posedge clk) if (bus.en_ff) acc <= alu_full[4:0];

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] imm);
    return {op, imm};
  endfunction

  task automatic fill_rom(input logic [8:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_prog();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!bus.halted && n < 120) begin tick(); n++; end
    n_total++;
    if (bus.halted !== 1'b1) $display("FAIL %s_halt: halted=%b want 1", name, bus.halted);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (bus.rom_addr !== 5'd0) $display("FAIL rst_rom_addr: got %0d want 0", bus.rom_addr); else n_pass++;
    n_total++; if (bus.f !== 3'b000) $display("FAIL rst_f: got %b want 000", bus.f); else n_pass++;
    n_total++; if (bus.operand !== 5'd0) $display("FAIL rst_operand: got %0d want 0", bus.operand); else n_pass++;
    n_total++; if ({bus.en_db, bus.en_ff, bus.en_r} !== 3'b000) $display("FAIL rst_enables: got %b want 000", {bus.en_db, bus.en_ff, bus.en_r}); else n_pass++;
    n_total++; if ({bus.busy, bus.halted} !== 2'b00) $display("FAIL rst_status: got %b want 00", {bus.busy, bus.halted}); else n_pass++;
    bus.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_wait: busy=%b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic();
    int first_halt = -1, n_r = 0;
    logic [4:0] acc_at_r = 5'd0;
    logic halt_busy = 1'b1;
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 5); rom[1] = mk(ADDI, 3); rom[2] = mk(OUT, 0); rom[3] = mk(HLT, 0);
    start_prog();
    for (int i = 0; i < 20; i++) begin
      if (cyc == 1) begin
        n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_fetch: got %b want 1", bus.busy); else n_pass++;
      end
      if (cyc == 3) begin
        n_total++; if (bus.f !== 3'b010) $display("FAIL basic_ldi_f: got %b want 010", bus.f); else n_pass++;
        n_total++; if (bus.operand !== 5'd5) $display("FAIL basic_ldi_operand: got %0d want 5", bus.operand); else n_pass++;
        n_total++; if ({bus.en_db, bus.en_ff, bus.en_r} !== 3'b110) $display("FAIL basic_ldi_en: got %b want 110", {bus.en_db, bus.en_ff, bus.en_r}); else n_pass++;
      end
      if (cyc == 6) begin
        n_total++; if (bus.f !== 3'b011) $display("FAIL basic_addi_f: got %b want 011", bus.f); else n_pass++;
      end
      if (bus.en_r) begin n_r++; acc_at_r = acc; end
      if (bus.halted && first_halt < 0) begin first_halt = cyc; halt_busy = bus.busy; end
      tick();
    end
    n_total++; if (n_r !== 1) $display("FAIL basic_en_r_count: got %0d want 1", n_r); else n_pass++;
    n_total++; if (acc_at_r !== 5'd8) $display("FAIL basic_out_value: got %0d want 8", acc_at_r); else n_pass++;
    n_total++; if (first_halt !== 13) $display("FAIL basic_halt_cycle: got %0d want 13", first_halt); else n_pass++;
    n_total++; if (halt_busy !== 1'b0) $display("FAIL basic_halt_busy: got %b want 0", halt_busy); else n_pass++;
  endtask

  task automatic test_jz();
    logic [4:0] exp_taken;
`ifdef ACC_SEQ_COND_JUMP_EN
    exp_taken = 5'd6;
`else
    exp_taken = 5'd3;
`endif
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 4); rom[1] = mk(SUBI, 4); rom[2] = mk(JZ, 6);
    start_prog();
    run_until(10);
    n_total++; if (bus.rom_addr !== exp_taken) $display("FAIL jz_taken: rom_addr=%0d want %0d", bus.rom_addr, exp_taken); else n_pass++;
    wait_halt("jz_taken");
    rom[1] = mk(SUBI, 3);
    start_prog();
    run_until(10);
    n_total++; if (bus.rom_addr !== 5'd3) $display("FAIL jz_fallthrough: rom_addr=%0d want 3", bus.rom_addr); else n_pass++;
    wait_halt("jz_fall");
  endtask

  task automatic test_jc();
    logic [4:0] exp_addr;
`ifdef ACC_SEQ_COND_JUMP_EN
    exp_addr = 5'd7;
`else
    exp_addr = 5'd3;
`endif
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 31); rom[1] = mk(ADDI, 1); rom[2] = mk(JC, 7);
    start_prog();
    run_until(10);
    n_total++; if (bus.rom_addr !== exp_addr) $display("FAIL jc_carry: rom_addr=%0d want %0d", bus.rom_addr, exp_addr); else n_pass++;
    wait_halt("jc");
  endtask

  task automatic test_wrap();
    fill_rom(9'd0);
    start_prog();
    run_until(94);
    n_total++; if (bus.rom_addr !== 5'd31) $display("FAIL wrap_addr31: rom_addr=%0d want 31", bus.rom_addr); else n_pass++;
    run_until(97);
    n_total++; if (bus.rom_addr !== 5'd0) $display("FAIL wrap_addr0: rom_addr=%0d want 0", bus.rom_addr); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL wrap_busy: busy=%b want 1", bus.busy); else n_pass++;
    run_until(100);
    n_total++; if (bus.rom_addr !== 5'd1) $display("FAIL wrap_addr1: rom_addr=%0d want 1", bus.rom_addr); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 2); rom[1] = mk(ADDI, 3); rom[2] = mk(OUT, 0); rom[3] = mk(HLT, 0);
    start_prog();
    run_until(6);
    n_total++; if ({bus.en_db, bus.en_ff} !== 2'b11) $display("FAIL rexec_pre_en: got %b want 11", {bus.en_db, bus.en_ff}); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if ({bus.en_db, bus.en_ff, bus.en_r} !== 3'b000) $display("FAIL rexec_enables: got %b want 000", {bus.en_db, bus.en_ff, bus.en_r}); else n_pass++;
    n_total++; if (bus.f !== 3'b000) $display("FAIL rexec_f: got %b want 000", bus.f); else n_pass++;
    n_total++; if (bus.operand !== 5'd0) $display("FAIL rexec_operand: got %0d want 0", bus.operand); else n_pass++;
    n_total++; if (bus.rom_addr !== 5'd0) $display("FAIL rexec_rom_addr: got %0d want 0", bus.rom_addr); else n_pass++;
    n_total++; if ({bus.busy, bus.halted} !== 2'b00) $display("FAIL rexec_status: got %b want 00", {bus.busy, bus.halted}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_prog();
    n_total++; if (bus.rom_addr !== 5'd0) $display("FAIL rexec_restart_addr: got %0d want 0", bus.rom_addr); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL rexec_restart_busy: got %b want 1", bus.busy); else n_pass++;
    wait_halt("rexec");
    n_total++; if (acc !== 5'd5) $display("FAIL rexec_acc: got %0d want 5", acc); else n_pass++;
  endtask

  task automatic test_start_busy();
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 1); rom[1] = mk(LDI, 2); rom[2] = mk(LDI, 3); rom[3] = mk(HLT, 0);
    start_prog();
    tick();
    bus.start = 1'b1;
    run_until(4);
    n_total++; if (bus.rom_addr !== 5'd1) $display("FAIL busy_start_addr1: got %0d want 1", bus.rom_addr); else n_pass++;
    run_until(7);
    n_total++; if (bus.rom_addr !== 5'd2) $display("FAIL busy_start_addr2: got %0d want 2", bus.rom_addr); else n_pass++;
    run_until(10);
    bus.start = 1'b0;
    n_total++; if (bus.rom_addr !== 5'd3) $display("FAIL busy_start_addr3: got %0d want 3", bus.rom_addr); else n_pass++;
    run_until(12);
    n_total++; if (bus.halted !== 1'b0) $display("FAIL busy_halt_early: halted=%b want 0", bus.halted); else n_pass++;
    run_until(13);
    n_total++; if (bus.halted !== 1'b1) $display("FAIL busy_halt_cycle: halted=%b want 1", bus.halted); else n_pass++;
    n_total++; if (acc !== 5'd3) $display("FAIL busy_acc: got %0d want 3", acc); else n_pass++;
  endtask

  task automatic test_halt_restart();
    fill_rom(mk(HLT, 0));
    rom[0] = mk(LDI, 0);
    start_prog();
    wait_halt("restart_a");
    rom[0] = mk(JZ, 5);
    start_prog();
    n_total++; if (bus.rom_addr !== 5'd0) $display("FAIL restart_addr0: got %0d want 0", bus.rom_addr); else n_pass++;
    run_until(4);
    n_total++; if (bus.rom_addr !== 5'd1) $display("FAIL restart_flags_cleared: rom_addr=%0d want 1", bus.rom_addr); else n_pass++;
    wait_halt("restart_b");
  endtask

  initial begin
    bus.start = 1'b0;
    reset = 1'b1;
    fill_rom(mk(HLT, 0));
    test_reset();
    test_basic();
    test_jz();
    test_jc();
    test_wrap();
    test_reset_exec();
    test_start_busy();
    test_halt_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Fetch/decode/execute controller for the 5-bit accumulator datapath: ALU, accumulator register, operand bus driver and result bus driver. It reads 9-bit instructions from an external synchronous program ROM. Each instruction drives the ALU function select, the operand value and the bus/register enables for exactly one execute cycle. It also keeps the zero and carry flags for conditional jumps. It sits between the program ROM and the processor top level and is the only source of the datapath control strobes.

## Interface
- PC_W, 5, program counter / ROM address width; the jump target field is 5 bits, zero-extended to PC_W
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  level-sampled; starts execution from address 0 when in IDLE or HALT
- instr  input  9  ROM data, valid one cycle after rom_addr; [8:5] opcode, [4:0] immediate/target
- alu_c  input  1  ALU carry output
- alu_ze  input  1  ALU zero output
- rom_addr  output  PC_W  program ROM address
- f  output  3  ALU function select
- operand  output  5  value fed to the operand bus driver
- en_db  output  1  operand bus driver enable
- en_ff  output  1  accumulator load enable
- en_r  output  1  result bus driver enable (output strobe)
- busy  output  1  high in FETCH, DECODE and EXEC
- halted  output  1  high in HALT

## Operation
- State machine has five states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: wait for start=1, then clear pc and flags and go to FETCH.
  - FETCH: rom_addr=pc; go to DECODE.
  - DECODE: latch instr into ir; go to EXEC.
  - EXEC: drive the controls for ir, update pc, go to FETCH. If ir is HALT, go to HALT instead.
  - HALT: wait for start=1, then restart exactly as from IDLE.
- start is ignored while busy.
- Opcodes (imm = ir[4:0]):
  - 0000 NOP: no strobes.
  - 0001 LDI: f=010, operand=imm, en_db=1, en_ff=1.
  - 0010 ADDI: f=011, operand=imm, en_db=1, en_ff=1.
  - 0011 SUBI: f=001, operand=imm, en_db=1, en_ff=1.
  - 0100 NANDI: f=100, operand=imm, en_db=1, en_ff=1.
  - 0101 OUT: f=000, en_r=1.
  - 0110 JMP: pc=imm.
  - 0111 JZ: pc=imm if zflag=1, else pc+1.
  - 1000 JC: pc=imm if cflag=1, else pc+1.
  - 1111 HALT.
  - All other opcodes execute as NOP.
- Flags:
  - zflag and cflag are registered on the clock edge that ends EXEC of LDI, ADDI, SUBI and NANDI only, sampled from alu_ze and alu_c.
  - Other instructions leave the flags unchanged.
- Arithmetic:
  - pc+1 is modulo 2^PC_W, so address 31 wraps to 0 at PC_W=5.
  - Jump targets are zero-extended to PC_W.
- Outside EXEC: f=000, operand=0, and all enables are 0.

## Timing
- Every instruction takes 3 cycles (FETCH, DECODE, EXEC); there is no pipelining.
- Control outputs are combinational from state and ir, and are valid for the whole EXEC cycle.
- The accumulator and flags update on the rising edge that ends EXEC.
- rom_addr is held from FETCH through EXEC. The ROM returns instr on the edge ending FETCH, and ir captures it on the edge ending DECODE.
- A jump takes effect in the next FETCH; there are no delay slots.
- Reset behaviour:
  - Reset values: state=IDLE, pc=0, ir=0, zflag=0, cflag=0, rom_addr=0, f=000, operand=0, en_db=en_ff=en_r=0, busy=0, halted=0.
  - Reset asserted mid-instruction, including during EXEC, aborts immediately. No strobe may persist after reset rises.
- start asserted in the same cycle as reset deassertion is ignored. It is sampled on the first edge after that.

## Configuration
- ACC_SEQ_COND_JUMP_EN defined: JZ and JC behave as specified, and zflag/cflag are implemented.
- ACC_SEQ_COND_JUMP_EN undefined: opcodes 0111 and 1000 decode as NOP. The flag registers are removed and alu_c/alu_ze are unused. All other behaviour is identical.

## Test plan
- LDI 5; ADDI 3; OUT; HALT -> en_r high for exactly one cycle with datapath result 8. halted rises 12 cycles after the first FETCH; busy=0 in HALT.
- LDI 4; SUBI 4; JZ 6 -> zflag=1 and the next rom_addr is 6. With LDI 4; SUBI 3 instead -> falls through to address 3.
- LDI 31; ADDI 1; JC 7 -> cflag=1 and jumps to 7. With ACC_SEQ_COND_JUMP_EN undefined -> behaves as NOP and goes to pc+1.
- 31 NOPs at addresses 0-30 plus a NOP at 31 -> rom_addr wraps from 31 to 0 with no stall.
- Reset asserted during EXEC of ADDI -> en_ff and en_db drop immediately and every output takes its reset value. start then restarts from address 0.
- start pulsed while busy -> ignored with no pc change. start in HALT -> flags cleared and fetch restarts at 0.
